// File: rtl/camera_exposure_fsm.sv
// camera_exposure_fsm: erase / timed exposure / two-row readout sequencer for one capture per init request.
module camera_exposure_fsm #(
   parameter int EX_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            init,
   input  logic [EX_W-1:0] ex_init,
   output logic            erase,
   output logic            expose,
   output logic            nre_1,
   output logic            nre_2,
   output logic            adc,
   output logic            busy
);
   typedef enum logic [1:0] {S_IDLE, S_EXPOSURE, S_READOUT} state_t;
   state_t          r_state, w_state_nx;
   logic [EX_W-1:0] r_cnt, w_cnt_nx;
   logic [2:0]      r_step, w_step_nx;
   logic            r_erase, r_expose, r_nre_1, r_nre_2, r_adc, r_busy;
   logic            w_rd;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_step   <= '0;
         r_erase  <= 1'b1;
         r_expose <= 1'b0;
         r_nre_1  <= 1'b1;
         r_nre_2  <= 1'b1;
         r_adc    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_step   <= w_step_nx;
         r_erase  <= w_state_nx == S_IDLE;
         r_expose <= w_state_nx == S_EXPOSURE;
         r_nre_1  <= !(w_rd && w_step_nx < 3'd3);
         r_nre_2  <= !(w_rd && w_step_nx[2] && w_step_nx != 3'd7);
         r_adc    <= w_rd && w_step_nx[1:0] == 2'b01;
         r_busy   <= w_state_nx != S_IDLE;
      end
   end
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_step_nx  = r_step;
      case (r_state)
         S_IDLE: if (init) begin
            w_state_nx = S_EXPOSURE;
            w_cnt_nx   = (ex_init == '0) ? EX_W'(1) : ex_init;
         end
         S_EXPOSURE: if (r_cnt <= EX_W'(1)) begin
            w_state_nx = S_READOUT;
            w_step_nx  = 3'd0;
         end else begin
            w_cnt_nx = r_cnt - EX_W'(1);
         end
         S_READOUT: if (r_step == 3'd7) w_state_nx = S_IDLE;
                    else w_step_nx = r_step + 3'd1;
         default: w_state_nx = S_IDLE;
      endcase
   end
   // outputs are decoded from the next state so they are registered yet line up with the state
   assign w_rd   = w_state_nx == S_READOUT;
   assign erase  = r_erase;
   assign expose = r_expose;
   assign nre_1  = r_nre_1;
   assign nre_2  = r_nre_2;
   assign adc    = r_adc;
   assign busy   = r_busy;
endmodule

// File: tb/tb_camera_exposure_fsm.sv
// tb_camera_exposure_fsm: scoreboard bench; a capture-plan model pushes one expected output word per cycle.
module tb_camera_exposure_fsm;
   logic       clk, reset, init;
   logic [4:0] ex_init;
   logic       erase, expose, nre_1, nre_2, adc, busy;
   int         tests = 0, fails = 0;
   // expected word layout: {erase, expose, nre_1, nre_2, adc, busy}
   localparam logic [5:0] IDLE_V = 6'b101100;
   localparam logic [5:0] EXP_V  = 6'b011101;
   logic [5:0] ro [8] = '{6'b000101, 6'b000111, 6'b000101, 6'b001101,
                          6'b001001, 6'b001011, 6'b001001, 6'b001101};
   logic [5:0] plan [$];
   logic [5:0] exp_q [$];

   camera_exposure_fsm #(.EX_W(5)) dut (
      .clk(clk), .reset(reset), .init(init), .ex_init(ex_init),
      .erase(erase), .expose(expose), .nre_1(nre_1), .nre_2(nre_2), .adc(adc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      logic [5:0] e;
      int n;
      if (reset) begin
         plan.delete();
         e = IDLE_V;
      end else if (plan.size() == 0 && init) begin
         n = (ex_init == 0) ? 1 : int'(ex_init);
         for (int k = 0; k < n; k++) plan.push_back(EXP_V);
         for (int s = 0; s < 8; s++) plan.push_back(ro[s]);
         plan.push_back(IDLE_V);
         e = plan.pop_front();
      end else if (plan.size() != 0) begin
         e = plan.pop_front();
      end else begin
         e = IDLE_V;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      logic [5:0] e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {erase, expose, nre_1, nre_2, adc, busy};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL outputs t=%0t got %b want %b", $time, a, e);
         end
         tests++;
         if (!nre_1 && !nre_2) begin
            fails++;
            $display("FAIL nre_overlap t=%0t got nre_1=%b nre_2=%b want not both 0", $time, nre_1, nre_2);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic capture_latency(input logic [4:0] ex, input int want);
      int cnt = 0;
      init = 1'b1;
      ex_init = ex;
      tick(1);
      init = 1'b0;
      while (busy === 1'b1 && cnt < 200) begin
         cnt++;
         tick(1);
      end
      tests++;
      if (cnt != want) begin
         fails++;
         $display("FAIL latency ex_init=%0d got %0d want %0d", ex, cnt, want);
      end
   endtask

   initial begin
      reset = 1'b1;
      init = 1'b1;
      ex_init = 5'd16;
      tick(2);
      reset = 1'b0;
      init = 1'b0;
      tick(2);
      capture_latency(5'd16, 24);
      capture_latency(5'd2, 10);
      capture_latency(5'd30, 38);
      capture_latency(5'd0, 9);
      init = 1'b1;
      ex_init = 5'd10;
      tick(1);
      init = 1'b0;
      tick(2);
      ex_init = 5'd3;
      tick(9);
      init = 1'b1;
      tick(1);
      init = 1'b0;
      tick(20);
      init = 1'b1;
      ex_init = 5'd4;
      tick(13 * 3);
      init = 1'b0;
      tick(15);
      init = 1'b1;
      ex_init = 5'd10;
      tick(1);
      init = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(3);
      init = 1'b1;
      ex_init = 5'd5;
      tick(1);
      init = 1'b0;
      tick(9);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(12);
      for (int i = 0; i < 600; i++) begin
         init = ($urandom_range(0, 3) == 0);
         ex_init = 5'($urandom_range(0, 31));
         reset = ($urandom_range(0, 80) == 0);
         tick(1);
      end
      reset = 1'b0;
      init = 1'b0;
      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
